spi_master_shifter: RTL and testbench



---
 rtl/spi_pkg.sv | 27 ++
 rtl/spi_clk_gen.sv | 48 ++++
 rtl/spi_master_shifter.sv | 152 +++++++++++++++
 tb/tb_spi_master_shifter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared types and default sizes for the SPI master shifter.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

  localparam int SPI_DATA_WIDTH = 8;
  localparam int SPI_DIV_WIDTH  = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    SHIFT = 3'd3,
    PUSH  = 3'd4,
    HOLD  = 3'd5
  } spi_shift_state_e;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

endpackage
`default_nettype wire

// File: rtl/spi_clk_gen.sv
`default_nettype none
// ============================================================================
// Module      : spi_clk_gen
// Description : SCLK divider: wrap strobe, leading/trailing flag, edge count.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_clk_gen #(
  parameter int DIV_WIDTH = 8,
  parameter int EDGES     = 16,
  parameter int EW        = $clog2(EDGES + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 run_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 strobe_o,
  output logic                 leading_o,
  output logic                 last_o
);

  logic [DIV_WIDTH-1:0] r_cnt;
  logic [EW-1:0]        r_edge_cnt;
  logic                 w_strobe;

  assign w_strobe = run_i && (r_cnt == div_i);

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_cnt      <= '0;
      r_edge_cnt <= '0;
    end else if (run_i) begin
      if (w_strobe) begin
        r_cnt      <= '0;
        r_edge_cnt <= r_edge_cnt + 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Edge number is r_edge_cnt+1, so an even count marks an odd (leading) edge.
  assign strobe_o  = w_strobe;
  assign leading_o = ~r_edge_cnt[0];
  assign last_o    = w_strobe && (r_edge_cnt == EW'(EDGES - 1));

endmodule
`default_nettype wire

// File: rtl/spi_master_shifter.sv
`default_nettype none
// ============================================================================
// Module      : spi_master_shifter
// Description : Full-duplex SPI master between TX/RX FIFOs and the SPI pads.
//               Optional SPI_LOOPBACK_EN adds loopback_i (MOSI->RX, pads idle).
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master_shifter
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = SPI_DATA_WIDTH,
  parameter int DIV_WIDTH  = SPI_DIV_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic [DIV_WIDTH-1:0]  clk_div_i,
  input  logic                  cpol_i,
  input  logic                  cpha_i,
  input  logic                  tx_empty_i,
  output logic                  tx_rd_o,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  rx_full_i,
  output logic                  rx_wr_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  sclk_o,
  output logic                  mosi_o,
  input  logic                  miso_i,
  output logic                  cs_n_o,
  output logic                  busy_o,
`ifdef SPI_LOOPBACK_EN
  input  logic                  loopback_i,
`endif
  output logic                  rx_ovf_o
);

  localparam int EDGES = 2 * DATA_WIDTH;

  spi_shift_state_e      r_state, w_next;
  spi_mode_t             r_mode;
  logic [DIV_WIDTH-1:0]  r_div;
  logic [DATA_WIDTH-1:0] r_tx_sr, r_rx_sr, r_rx_data;
  logic                  r_sclk, r_mosi, r_cs_n, r_ovf;
  logic                  w_strobe, w_leading, w_last;
  logic                  w_in_shift, w_sample, w_shift, w_miso_bit;
  logic [DATA_WIDTH-1:0] w_rx_next;

  spi_clk_gen #(
    .DIV_WIDTH (DIV_WIDTH),
    .EDGES     (EDGES)
  ) u_clk_gen (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   ((r_state == LOAD) || (r_state == PUSH)),
    .run_i     ((r_state == SHIFT) || (r_state == HOLD)),
    .div_i     (r_div),
    .strobe_o  (w_strobe),
    .leading_o (w_leading),
    .last_o    (w_last)
  );

`ifdef SPI_LOOPBACK_EN
  assign w_miso_bit = loopback_i ? r_mosi : miso_i;
  assign sclk_o     = (loopback_i && (r_state != IDLE)) ? r_mode.cpol : r_sclk;
  assign cs_n_o     = loopback_i ? 1'b1 : r_cs_n;
`else
  assign w_miso_bit = miso_i;
  assign sclk_o     = r_sclk;
  assign cs_n_o     = r_cs_n;
`endif

  // cpha=0 samples leading edges, cpha=1 trailing; the final edge never shifts.
  assign w_in_shift = w_strobe && (r_state == SHIFT);
  assign w_sample   = w_in_shift && (w_leading ^ r_mode.cpha);
  assign w_shift    = w_in_shift && !(w_leading ^ r_mode.cpha) && !w_last;
  assign w_rx_next  = {r_rx_sr[DATA_WIDTH-2:0], w_miso_bit};

  assign tx_rd_o   = (r_state == FETCH);
  assign rx_wr_o   = (r_state == PUSH) && !rx_full_i;
  assign busy_o    = (r_state != IDLE);
  assign mosi_o    = r_mosi;
  assign rx_data_o = r_rx_data;
  assign rx_ovf_o  = r_ovf;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (en_i && !tx_empty_i) w_next = FETCH;
      FETCH:   w_next = LOAD;
      LOAD:    w_next = SHIFT;
      SHIFT:   if (w_last) w_next = PUSH;
      PUSH:    w_next = (en_i && !tx_empty_i) ? FETCH : HOLD;
      HOLD:    if (w_strobe) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mode    <= '0;
      r_div     <= '0;
      r_tx_sr   <= '0;
      r_rx_sr   <= '0;
      r_rx_data <= '0;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_cs_n    <= 1'b1;
      r_ovf     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_sclk <= cpol_i;
          r_cs_n <= 1'b1;
        end
        FETCH: r_cs_n <= 1'b0;
        LOAD: begin
          r_mode  <= '{cpol: cpol_i, cpha: cpha_i};
          r_div   <= clk_div_i;
          r_rx_sr <= '0;
          if (!cpha_i) begin
            r_mosi  <= tx_data_i[DATA_WIDTH-1];
            r_tx_sr <= tx_data_i << 1;
          end else begin
            r_tx_sr <= tx_data_i;
          end
        end
        SHIFT: begin
          if (w_strobe) r_sclk <= ~r_sclk;
          if (w_sample) r_rx_sr <= w_rx_next;
          if (w_shift) begin
            r_mosi  <= r_tx_sr[DATA_WIDTH-1];
            r_tx_sr <= {r_tx_sr[DATA_WIDTH-2:0], 1'b0};
          end
          if (w_last) r_rx_data <= r_mode.cpha ? w_rx_next : r_rx_sr;
        end
        PUSH: begin
          r_sclk <= r_mode.cpol;
          if (rx_full_i) r_ovf <= 1'b1;
        end
        HOLD: if (w_strobe) r_cs_n <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_master_shifter.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_master_shifter
// Description : Directed bench with FIFO/slave models and RX scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master_shifter;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       en_i = 1'b1;
  logic [7:0] clk_div_i = 8'd1;
  logic       cpol_i = 1'b0;
  logic       cpha_i = 1'b0;
  logic       tx_empty_i = 1'b1;
  logic       tx_rd_o;
  logic [7:0] tx_data_i = 8'h00;
  logic       rx_full_i = 1'b0;
  logic       rx_wr_o;
  logic [7:0] rx_data_o;
  logic       sclk_o, mosi_o, cs_n_o, busy_o, rx_ovf_o;
  logic       miso_i = 1'b0;

  always #5 clk = ~clk;

  spi_master_shifter #(.DATA_WIDTH(8), .DIV_WIDTH(8)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .en_i       (en_i),
    .clk_div_i  (clk_div_i),
    .cpol_i     (cpol_i),
    .cpha_i     (cpha_i),
    .tx_empty_i (tx_empty_i),
    .tx_rd_o    (tx_rd_o),
    .tx_data_i  (tx_data_i),
    .rx_full_i  (rx_full_i),
    .rx_wr_o    (rx_wr_o),
    .rx_data_o  (rx_data_o),
    .sclk_o     (sclk_o),
    .mosi_o     (mosi_o),
    .miso_i     (miso_i),
    .cs_n_o     (cs_n_o),
    .busy_o     (busy_o),
`ifdef SPI_LOOPBACK_EN
    .loopback_i (1'b0),
`endif
    .rx_ovf_o   (rx_ovf_o)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] tx_q[$];
  logic [7:0] exp_mosi[$];
  logic [7:0] slv_q[$];
  logic [7:0] exp_rx[$];

  int cyc = 0, n_txrd = 0, n_rxwr = 0, n_rise = 0, n_fedge = 0;
  int t_rlast = 0, r_per = 0, t_push = 0, t_csr = 0;
  logic [7:0] s_out = 8'h00, s_in = 8'h00;
  int s_obit = 0, s_ibit = 0;
  logic p_sclk, p_cs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic slave_drive();
    if (s_obit == 0) s_out = (slv_q.size() != 0) ? slv_q[0] : 8'h00;
    miso_i = s_out[7 - s_obit];
    s_obit = (s_obit == 7) ? 0 : s_obit + 1;
  endtask

  task automatic slave_capture();
    s_in = {s_in[6:0], mosi_o};
    s_ibit++;
    if (s_ibit == 8) begin
      s_ibit = 0;
      if (exp_mosi.size() != 0) chk("mosi_word", s_in, exp_mosi.pop_front());
      else chk("mosi_unexpected", cs_n_o, 1'b1);
      if (slv_q.size() != 0) void'(slv_q.pop_front());
    end
  endtask

  // TX FIFO model, SPI slave model, RX scoreboard and edge monitors.
  always @(negedge clk) begin
    cyc++;
    if (tx_rd_o) begin
      n_txrd++;
      if (tx_q.size() != 0) tx_data_i = tx_q.pop_front();
      else chk("rd_while_empty", tx_rd_o, 1'b0);
    end
    tx_empty_i = (tx_q.size() == 0);
    if (rx_wr_o) begin
      n_rxwr++;
      t_push = cyc;
      if (exp_rx.size() != 0) chk("rx_data", rx_data_o, exp_rx.pop_front());
      else chk("rx_wr_unexpected", rx_wr_o, 1'b0);
    end
    if (cs_n_o === 1'b1) begin
      if (p_cs === 1'b0) t_csr = cyc;
      s_obit = 0;
      s_ibit = 0;
      n_fedge = 0;
    end else if (cs_n_o === 1'b0) begin
      if (p_cs === 1'b1 && !cpha_i) slave_drive();
      if (sclk_o !== p_sclk) begin
        n_fedge++;
        if (sclk_o === 1'b1) begin
          n_rise++;
          r_per = cyc - t_rlast;
          t_rlast = cyc;
        end
        if ((sclk_o !== cpol_i) ^ cpha_i) slave_capture();
        else slave_drive();
      end
    end
    p_sclk = sclk_o;
    p_cs   = cs_n_o;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic queue_word(input logic [7:0] tx, input logic [7:0] rx, input bit push);
    tx_q.push_back(tx);
    exp_mosi.push_back(tx);
    slv_q.push_back(rx);
    if (push) exp_rx.push_back(rx);
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    repeat (4) tick();
    while (busy_o && k < 3000) begin
      tick();
      k++;
    end
    chk({tag, "_done"}, busy_o, 1'b0);
    chk({tag, "_cs_idle"}, cs_n_o, 1'b1);
  endtask

  typedef struct {logic cpol; logic cpha; logic [7:0] div;} mode_t;
  mode_t modes[3] = '{'{1'b0, 1'b1, 8'd0}, '{1'b1, 1'b0, 8'd2}, '{1'b1, 1'b1, 8'd1}};

  initial begin
    int b_rd, b_wr, b_rise, k;

    // Reset state
    repeat (3) tick();
    chk("rst_sclk", sclk_o, 1'b0);
    chk("rst_mosi", mosi_o, 1'b0);
    chk("rst_cs_n", cs_n_o, 1'b1);
    chk("rst_tx_rd", tx_rd_o, 1'b0);
    chk("rst_rx_wr", rx_wr_o, 1'b0);
    chk("rst_rx_data", rx_data_o, 8'h00);
    chk("rst_ovf", rx_ovf_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    rst_i = 1'b0;
    repeat (2) tick();

    // Mode 0, div 1: A5 out, 3C in
    b_rise = n_rise; b_wr = n_rxwr;
    queue_word(8'hA5, 8'h3C, 1'b1);
    wait_done("m0");
    chk("m0_rises", n_rise - b_rise, 8);
    chk("m0_period", r_per, 4);
    chk("m0_rx_wr_cnt", n_rxwr - b_wr, 1);
    chk("m0_hold_len", t_csr - t_push - 1, 2);

    // Modes 1..3: 81 out, 7E in
    foreach (modes[i]) begin
      cpol_i = modes[i].cpol; cpha_i = modes[i].cpha; clk_div_i = modes[i].div;
      repeat (2) tick();
      chk($sformatf("mode%0d_idle_sclk", i + 1), sclk_o, modes[i].cpol);
      b_rise = n_rise;
      queue_word(8'h81, 8'h7E, 1'b1);
      wait_done($sformatf("mode%0d", i + 1));
      chk($sformatf("mode%0d_rises", i + 1), n_rise - b_rise, 8);
      chk($sformatf("mode%0d_period", i + 1), r_per, 2 * (modes[i].div + 1));
      chk($sformatf("mode%0d_sclk_end", i + 1), sclk_o, modes[i].cpol);
    end

    // Back-to-back: three words under one chip select
    cpol_i = 1'b0; cpha_i = 1'b0; clk_div_i = 8'd1;
    repeat (2) tick();
    b_rd = n_txrd; b_wr = n_rxwr; k = t_csr;
    queue_word(8'h11, 8'hC1, 1'b1);
    queue_word(8'h22, 8'hC2, 1'b1);
    queue_word(8'h33, 8'hC3, 1'b1);
    repeat (4) tick();
    while (n_rxwr - b_wr < 3 && busy_o) tick();
    chk("b2b_cs_low", t_csr, k);
    wait_done("b2b");
    chk("b2b_tx_rd", n_txrd - b_rd, 3);
    chk("b2b_rx_wr", n_rxwr - b_wr, 3);

    // RX overflow: word dropped, flag sticky
    b_wr = n_rxwr;
    rx_full_i = 1'b1;
    queue_word(8'hC3, 8'h5A, 1'b0);
    wait_done("ovf");
    chk("ovf_no_wr", n_rxwr - b_wr, 0);
    chk("ovf_flag", rx_ovf_o, 1'b1);
    rx_full_i = 1'b0;
    queue_word(8'h0F, 8'hF0, 1'b1);
    wait_done("ovf2");
    chk("ovf_wr_after", n_rxwr - b_wr, 1);
    chk("ovf_sticky", rx_ovf_o, 1'b1);

    // en_i dropped mid-frame with two words still queued
    b_rd = n_txrd; b_wr = n_rxwr; b_rise = n_rise;
    queue_word(8'h44, 8'hB4, 1'b1);
    queue_word(8'h55, 8'hB5, 1'b1);
    queue_word(8'h66, 8'hB6, 1'b1);
    k = 0;
    while (n_rise - b_rise < 2 && k < 200) begin tick(); k++; end
    chk("en_frame_started", busy_o, 1'b1);
    en_i = 1'b0;
    wait_done("en_drop");
    repeat (10) tick();
    chk("en_drop_tx_rd", n_txrd - b_rd, 1);
    chk("en_drop_rx_wr", n_rxwr - b_wr, 1);
    chk("en_drop_idle", busy_o, 1'b0);
    en_i = 1'b1;
    wait_done("en_resume");
    chk("en_resume_rx_wr", n_rxwr - b_wr, 3);

    // Reset at edge 5 aborts the frame
    b_wr = n_rxwr;
    queue_word(8'h96, 8'h69, 1'b0);
    k = 0;
    repeat (4) tick();
    while (n_fedge < 5 && k < 200) begin tick(); k++; end
    chk("rst_mid_edge5", n_fedge, 5);
    rst_i = 1'b1;
    tick();
    chk("rst_mid_cs_n", cs_n_o, 1'b1);
    chk("rst_mid_sclk", sclk_o, 1'b0);
    chk("rst_mid_busy", busy_o, 1'b0);
    chk("rst_mid_rx_wr", rx_wr_o, 1'b0);
    chk("rst_mid_ovf", rx_ovf_o, 1'b0);
    rst_i = 1'b0;
    tx_q.delete(); exp_mosi.delete(); slv_q.delete();
    repeat (20) tick();
    chk("rst_mid_no_push", n_rxwr - b_wr, 0);
    chk("sb_drained", exp_rx.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
